// File: rtl/block_lock_if.sv
// RX gearbox-to-descrambler signal bundle around the block lock stage.
// The slave modport is the block_lock view; master is the upstream/downstream driver view.
interface block_lock_if #(
  parameter int DATA_WIDTH = 32,
  parameter int HDR_WIDTH  = 2
);
  logic [DATA_WIDTH-1:0] i_rx_data;
  logic [HDR_WIDTH-1:0]  i_rx_sync_hdr;
  logic                  i_rx_data_valid;
  logic                  i_rx_hdr_valid;
  logic [DATA_WIDTH-1:0] o_rx_data;
  logic [HDR_WIDTH-1:0]  o_rx_sync_hdr;
  logic                  o_rx_data_valid;
  logic                  o_rx_hdr_valid;
  logic                  o_slip;
  logic                  o_block_lock;

  modport slave (
    input  i_rx_data, i_rx_sync_hdr, i_rx_data_valid, i_rx_hdr_valid,
    output o_rx_data, o_rx_sync_hdr, o_rx_data_valid, o_rx_hdr_valid,
    output o_slip, o_block_lock
  );

  modport master (
    output i_rx_data, i_rx_sync_hdr, i_rx_data_valid, i_rx_hdr_valid,
    input  o_rx_data, o_rx_sync_hdr, o_rx_data_valid, o_rx_hdr_valid,
    input  o_slip, o_block_lock
  );
endinterface

// File: rtl/block_lock.sv
// 66b block lock FSM: slips the gearbox until sync headers align, then
// passes data through one register stage, marked valid only while locked.
module block_lock #(
  parameter int DATA_WIDTH     = 32,
  parameter int HDR_WIDTH      = 2,
  parameter int SH_CNT_MAX     = 64,
  parameter int SH_INVALID_MAX = 16,
  parameter int SLIP_WAIT      = 32
) (
  input logic         i_clk,
  input logic         i_reset_n,
  block_lock_if.slave rx
);

  localparam int SH_W   = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W  = $clog2(SH_INVALID_MAX + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT);

  localparam logic [SH_W-1:0]   SH_MAX    = SH_W'(SH_CNT_MAX);
  localparam logic [INV_W-1:0]  INV_MAX   = INV_W'(SH_INVALID_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED  = 2'd0,
    ST_LOCKED    = 2'd1,
    ST_SLIP_WAIT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [SH_W-1:0]     sh_cnt_q, sh_cnt_d;
  logic [INV_W-1:0]    sh_inv_q, sh_inv_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                slip_q, slip_d;
  logic                lock_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [HDR_WIDTH-1:0]  hdr_q;
  logic                dv_q, hv_q;

  logic            sample;
  logic            hdr_good;
  logic            lock_next;
  logic [SH_W-1:0]  sh_inc;
  logic [INV_W-1:0] inv_inc;

  assign sample   = rx.i_rx_hdr_valid & rx.i_rx_data_valid;
  // Exactly one bit set (01 or 10) marks a valid sync header.
  assign hdr_good = ^rx.i_rx_sync_hdr;
  assign sh_inc   = (sh_cnt_q == SH_MAX)  ? sh_cnt_q : sh_cnt_q + SH_W'(1);
  assign inv_inc  = (sh_inv_q == INV_MAX) ? sh_inv_q : sh_inv_q + INV_W'(1);

  always_comb begin
    // NOTE: every variable gets a default first so no branch can infer a latch.
    state_d  = state_q;
    sh_cnt_d = sh_cnt_q;
    sh_inv_d = sh_inv_q;
    wait_d   = wait_q;
    slip_d   = 1'b0;

    unique case (state_q)
      ST_UNLOCKED: begin
        if (sample) begin
          if (!hdr_good) begin
            slip_d   = 1'b1;
            sh_cnt_d = '0;
            sh_inv_d = '0;
            state_d  = ST_SLIP_WAIT;
          end else if (sh_inc == SH_MAX) begin
            sh_cnt_d = '0;
            sh_inv_d = '0;
            state_d  = ST_LOCKED;
          end else begin
            sh_cnt_d = sh_inc;
          end
        end
      end

      ST_LOCKED: begin
        if (sample) begin
          sh_cnt_d = sh_inc;
          if (!hdr_good) sh_inv_d = inv_inc;
          // Too many bad headers wins over a window end on the same sample.
          if (!hdr_good && inv_inc == INV_MAX) begin
            slip_d   = 1'b1;
            sh_cnt_d = '0;
            sh_inv_d = '0;
            state_d  = ST_SLIP_WAIT;
          end else if (sh_inc == SH_MAX) begin
            sh_cnt_d = '0;
            sh_inv_d = '0;
          end
        end
      end

      ST_SLIP_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = ST_UNLOCKED;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      default: state_d = ST_UNLOCKED;
    endcase
  end

  assign lock_next = (state_d == ST_LOCKED);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q  <= ST_UNLOCKED;
      sh_cnt_q <= '0;
      sh_inv_q <= '0;
      wait_q   <= '0;
      slip_q   <= 1'b0;
      lock_q   <= 1'b0;
      data_q   <= '0;
      hdr_q    <= '0;
      dv_q     <= 1'b0;
      hv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_cnt_q <= sh_cnt_d;
      sh_inv_q <= sh_inv_d;
      wait_q   <= wait_d;
      slip_q   <= slip_d;
      lock_q   <= lock_next;
      data_q   <= rx.i_rx_data;
      hdr_q    <= rx.i_rx_sync_hdr;
      dv_q     <= rx.i_rx_data_valid & lock_next;
      hv_q     <= rx.i_rx_hdr_valid & rx.i_rx_data_valid & lock_next;
    end
  end

  assign rx.o_rx_data       = data_q;
  assign rx.o_rx_sync_hdr   = hdr_q;
  assign rx.o_rx_data_valid = dv_q;
  assign rx.o_rx_hdr_valid  = hv_q;
  assign rx.o_slip          = slip_q;
  assign rx.o_block_lock    = lock_q;

endmodule

// File: tb/tb_block_lock.sv
// Directed bench for block_lock: the driver queues the expected registered
// outputs per cycle, a monitor pops and compares them after each edge.
module tb_block_lock;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  hdr;
    logic        dv;
    logic        hv;
    logic        slip;
    logic        lock;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  block_lock_if #(.DATA_WIDTH(32), .HDR_WIDTH(2)) bus ();

  block_lock dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .rx        (bus.slave)
  );

  initial begin
    bus.i_rx_data       = '0;
    bus.i_rx_sync_hdr   = '0;
    bus.i_rx_data_valid = 1'b0;
    bus.i_rx_hdr_valid  = 1'b0;
  end

  function automatic logic [1:0] good_hdr(input int k);
    return (k % 2 != 0) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [1:0] bad_hdr(input int k);
    return (k % 2 != 0) ? 2'b11 : 2'b00;
  endfunction

  // One clock of stimulus; exp_lock/exp_slip are the values expected after the edge.
  task automatic cyc(input logic rst, input logic dv, input logic hv,
                     input logic [1:0] hdr, input logic exp_lock, input logic exp_slip);
    exp_t e;
    logic [31:0] d;
    @(negedge clk);
    d = $urandom;
    rst_n               = rst;
    bus.i_rx_data       = d;
    bus.i_rx_sync_hdr   = hdr;
    bus.i_rx_data_valid = dv;
    bus.i_rx_hdr_valid  = hv;
    if (!rst) begin
      e = '0;
    end else begin
      e.data = d;
      e.hdr  = hdr;
      e.dv   = dv & exp_lock;
      e.hv   = hv & dv & exp_lock;
      e.slip = exp_slip;
      e.lock = exp_lock;
    end
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are presented every cycle, one expectation per edge.
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = {bus.o_rx_data, bus.o_rx_sync_hdr, bus.o_rx_data_valid,
             bus.o_rx_hdr_valid, bus.o_slip, bus.o_block_lock};
        n_checks++;
        if (a !== e) begin
          n_errors++;
          $display("FAIL out_cycle_%0d t=%0t: got data=%h hdr=%b dv=%b hv=%b slip=%b lock=%b, expected data=%h hdr=%b dv=%b hv=%b slip=%b lock=%b",
                   n_checks, $time, a.data, a.hdr, a.dv, a.hv, a.slip, a.lock,
                   e.data, e.hdr, e.dv, e.hv, e.slip, e.lock);
        end
      end
    end
  end

  initial begin
    // Reset state
    cyc(1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0);

    // Lock acquire: 64 alternating good headers, lock on the 64th
    for (int i = 0; i < 64; i++) cyc(1'b1, 1'b1, 1'b1, good_hdr(i), i == 63, 1'b0);

    // Qualifiers while locked: bad headers without a full strobe must not count
    for (int i = 0; i < 20; i++) cyc(1'b1, (i % 2) != 0, (i % 2) == 0, bad_hdr(i / 2), 1'b1, 1'b0);

    // Lock hold: 15 bad at the end of one window, 15 bad at the start of the next
    for (int i = 0; i < 64; i++) cyc(1'b1, 1'b1, 1'b1, (i >= 49) ? bad_hdr(i) : good_hdr(i), 1'b1, 1'b0);
    for (int i = 0; i < 64; i++) cyc(1'b1, 1'b1, 1'b1, (i < 15) ? bad_hdr(i) : good_hdr(i), 1'b1, 1'b0);

    // Lock loss: 16th bad header lands on window position 64
    for (int i = 0; i < 64; i++)
      cyc(1'b1, 1'b1, 1'b1, (i >= 48) ? bad_hdr(i) : good_hdr(i), i != 63, i == 63);

    // Slip wait ignores all 32 strobes, the first header after it counts
    for (int i = 0; i < 32; i++) cyc(1'b1, 1'b1, 1'b1, bad_hdr(i), 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) cyc(1'b1, 1'b1, 1'b1, good_hdr(i), i == 63, 1'b0);

    // Reset while locked, mid-window, then 64 fresh good headers with qualifier noise
    for (int i = 0; i < 30; i++) cyc(1'b1, 1'b1, 1'b1, good_hdr(i), 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      if (i % 8 == 3) begin
        cyc(1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
      end
      cyc(1'b1, 1'b1, 1'b1, good_hdr(i), i == 63, 1'b0);
    end

    // Unlocked slip: 9 good then 2'b11, wait ignores 32 bad, next bad slips again
    cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1, 1'b1, good_hdr(i), 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 1'b1);
    for (int i = 0; i < 32; i++) cyc(1'b1, 1'b1, 1'b1, bad_hdr(i), 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1);

    // Reset during slip wait, then lock must come after exactly 64 good headers
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, good_hdr(i), 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) cyc(1'b1, 1'b1, 1'b1, good_hdr(i), i == 63, 1'b0);

    // Every queued expectation must have been consumed by the monitor
    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
